rpm_range_classifier: RTL and testbench
=======================================

Name: rpm_range_classifier

Overview:
- Tachometer front-end that feeds the engine revolution-range FSM.
- Counts rising edges of the raw crank/tach sensor pulse over a fixed measurement window and classifies the count into a 2-bit revolution range.
- `rev_range` drives the FSM's R input. `ign_on` is the same ignition signal that drives its A input.

Parameters:
- WINDOW_CYCLES, 1000: clk cycles per measurement window; legal range ≥ 2.
- CNT_W, 12: width of the pulse accumulator and of `pulse_count`.
- TH1, 10: minimum pulse count for range 01.
- TH2, 30: minimum pulse count for range 10.
- TH3, 60: minimum pulse count for range 11. Legality: 0 < TH1 < TH2 < TH3 ≤ 2^CNT_W-1.
- HYST, 2: downward hysteresis margin in pulses. Used only with RPM_HYST_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pulse_in  input  1  raw tach pulse, asynchronous to clk; high time ≥ 2 clk cycles
- ign_on  input  1  ignition on (1) / off (0), synchronous to clk
- rev_range  output  2  classified revolution range, registered
- range_valid  output  1  one-cycle strobe marking a `rev_range`/`pulse_count` update
- pulse_count  output  CNT_W  pulse count of the last completed window, registered

Behaviour:
- Reset (async): state=OFF; win_cnt=0; accumulator=0; sync flops=0; rev_range=00; range_valid=0; pulse_count=0.
- Input path:
  - 2-flop synchronizer on `pulse_in`, then a third flop for edge detection.
  - edge = sync2 & ~sync3. Each qualifying rising edge increments the accumulator exactly once.
  - Latency: 2 clk cycles from the sampled rise to the increment.
- Accumulator saturates at 2^CNT_W-1 and never wraps.
- State machine:
  - OFF: win_cnt and accumulator held at 0; rev_range=00; pulse_count=0; range_valid=0. Edges are ignored. ign_on=1 → ACQ.
  - ACQ (first window after ignition): counting runs, and rev_range stays 00 until the first window closes. At terminal count → RUN (with update).
  - RUN: continuous back-to-back windows, with an update at every terminal count.
  - Any state with ign_on=0 → OFF on the next clk edge. rev_range is forced to 00 on that edge, and any partial window is discarded.
- Window:
  - win_cnt runs 0..WINDOW_CYCLES-1.
  - Terminal cycle is win_cnt==WINDOW_CYCLES-1. An edge arriving in the terminal cycle belongs to the closing window.
  - In the terminal cycle, on the next clk edge:
    - pulse_count ← final count.
    - rev_range ← classification.
    - range_valid=1 for exactly one cycle.
    - accumulator ← 0 and win_cnt ← 0.
  - Window period is exactly WINDOW_CYCLES, with no dead cycles.
- Classification on count c (unsigned):
  - c < TH1 → 00
  - TH1 ≤ c < TH2 → 01
  - TH2 ≤ c < TH3 → 10
  - c ≥ TH3 → 11
- ign_on falling in the terminal cycle: the OFF transition wins. No update and no range_valid.
- Reset mid-window: immediate return to reset values. The partial count is lost.

Optional Feature:
- Macro RPM_HYST_EN.
- Defined:
  - raw = class(c); down = class(c+HYST), computed in CNT_W+1 bits.
  - If raw ≥ current rev_range, new = raw.
  - Otherwise, new = min(current rev_range, down).
  - Upward transitions are unaffected. Applies in RUN only. ACQ uses raw, and OFF still forces 00.
- Not defined: new = raw always. The HYST parameter is unused.

Test Plan (WINDOW_CYCLES=100, TH1=5, TH2=10, TH3=20, HYST=2, CNT_W=8):
- Reset, ign_on=1, no pulses → range_valid pulse exactly 100 cycles after entering ACQ; rev_range=00; pulse_count=0; pulses repeat every 100 cycles.
- Windows with 4, 5, 9, 10, 19, 20 pulses (each 3 cycles wide) → rev_range 00, 01, 01, 10, 10, 11; pulse_count matches each count.
- 300 pulses forced into one window with 2-cycle spacing (pulse_in high 2 cycles, low 2 cycles; about 25 fit in a 100-cycle window, so WINDOW_CYCLES is widened to 1200 for this test) → pulse_count saturates at 255; rev_range=11.
- ign_on dropped at cycle 50 of a window showing 10 → rev_range=00 next cycle, no range_valid. ign_on reasserted → first range_valid exactly 100 cycles later.
- Edge timed to land in the terminal cycle → counted in the closing window (e.g. 4+1=5 → 01); next window starts at 0.
- RPM_HYST_EN, starting from 10: 9 pulses → stays 10; 7 pulses → 01. Without the macro, 9 pulses → 01.

Source files
------------

// File: rtl/rpm_range_if.sv
// Tach classifier bus: raw pulse and ignition in, classified range, strobe and count out.
interface rpm_range_if #(
  parameter int unsigned CNT_W = 12
);
  logic             pulse_in;
  logic             ign_on;
  logic [1:0]       rev_range;
  logic             range_valid;
  logic [CNT_W-1:0] pulse_count;

  modport master (
    output pulse_in,
    output ign_on,
    input  rev_range,
    input  range_valid,
    input  pulse_count
  );

  modport slave (
    input  pulse_in,
    input  ign_on,
    output rev_range,
    output range_valid,
    output pulse_count
  );
endinterface

// File: rtl/rpm_range_classifier.sv
// Counts tach pulse edges per fixed window and classifies the count into a 2-bit rev range.
// Optional downward hysteresis in RUN enabled by defining RPM_HYST_EN.
module rpm_range_classifier #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned TH1           = 10,
  parameter int unsigned TH2           = 30,
  parameter int unsigned TH3           = 60,
  parameter int unsigned HYST          = 2
) (
  input  logic        clk,
  input  logic        reset,
  rpm_range_if.slave  bus
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
  localparam int unsigned EXT_W = CNT_W + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ACQ = 2'd1,
    ST_RUN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [1:0]       rev_range_q, rev_range_d;
  logic             range_valid_q, range_valid_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;

  logic             edge_c;
  logic             terminal_c;
  logic [CNT_W-1:0] acc_inc_c;
  logic [1:0]       raw_c;
  logic [1:0]       new_range_c;

  function automatic logic [1:0] classify(input logic [EXT_W-1:0] c);
    logic [1:0] r;
    if (c >= EXT_W'(TH3))      r = 2'b11;
    else if (c >= EXT_W'(TH2)) r = 2'b10;
    else if (c >= EXT_W'(TH1)) r = 2'b01;
    else                       r = 2'b00;
    return r;
  endfunction

  // sync_q[1] is the synchronized level, sync_q[2] its one-cycle-old copy
  assign edge_c     = sync_q[1] & ~sync_q[2];
  assign terminal_c = (win_q == WIN_LAST);
  assign acc_inc_c  = (edge_c && (acc_q != ACC_MAX)) ? acc_q + CNT_W'(1) : acc_q;
  assign raw_c      = classify({1'b0, acc_inc_c});

`ifdef RPM_HYST_EN
  logic [EXT_W-1:0] down_sum_c;
  logic [1:0]       down_c;
  logic [1:0]       hyst_c;

  // A downward step needs the count to clear the lower threshold by HYST pulses
  assign down_sum_c = {1'b0, acc_inc_c} + EXT_W'(HYST);
  assign down_c     = classify(down_sum_c);
  assign hyst_c     = (raw_c >= rev_range_q) ? raw_c :
                      ((down_c < rev_range_q) ? down_c : rev_range_q);
  assign new_range_c = (state_q == ST_RUN) ? hyst_c : raw_c;
`else
  assign new_range_c = raw_c;
`endif

  // State register and all datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_OFF;
      sync_q        <= '0;
      win_q         <= '0;
      acc_q         <= '0;
      rev_range_q   <= 2'b00;
      range_valid_q <= 1'b0;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      win_q         <= win_d;
      acc_q         <= acc_d;
      rev_range_q   <= rev_range_d;
      range_valid_q <= range_valid_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[1:0], bus.pulse_in};
    win_d         = win_q;
    acc_d         = acc_q;
    rev_range_d   = rev_range_q;
    range_valid_d = 1'b0;
    pulse_count_d = pulse_count_q;

    case (state_q)
      ST_OFF: begin
        win_d         = '0;
        acc_d         = '0;
        rev_range_d   = 2'b00;
        pulse_count_d = '0;
        if (bus.ign_on) state_d = ST_ACQ;
      end
      ST_ACQ, ST_RUN: begin
        if (!bus.ign_on) begin
          // Ignition loss beats a coinciding window close
          state_d       = ST_OFF;
          win_d         = '0;
          acc_d         = '0;
          rev_range_d   = 2'b00;
          pulse_count_d = '0;
        end else if (terminal_c) begin
          state_d       = ST_RUN;
          win_d         = '0;
          acc_d         = '0;
          pulse_count_d = acc_inc_c;
          rev_range_d   = new_range_c;
          range_valid_d = 1'b1;
        end else begin
          win_d = win_q + WIN_W'(1);
          acc_d = acc_inc_c;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign bus.rev_range   = rev_range_q;
  assign bus.range_valid = range_valid_q;
  assign bus.pulse_count = pulse_count_q;

endmodule

// File: tb/tb_rpm_range_classifier.sv
// Directed bench for rpm_range_classifier: window timing, classification, saturation, ignition and reset.
module tb_rpm_range_classifier;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN   = 100;

`ifdef RPM_HYST_EN
  localparam logic [1:0] EXP_H9 = 2'b10;
`else
  localparam logic [1:0] EXP_H9 = 2'b01;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rpm_range_if #(.CNT_W(CNT_W)) bus_a ();
  rpm_range_if #(.CNT_W(CNT_W)) bus_b ();

  rpm_range_classifier #(
    .WINDOW_CYCLES(WIN), .CNT_W(CNT_W), .TH1(5), .TH2(10), .TH3(20), .HYST(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  rpm_range_classifier #(
    .WINDOW_CYCLES(1200), .CNT_W(CNT_W), .TH1(5), .TH2(10), .TH3(20), .HYST(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Counts negedges until range_valid on bus_a is seen; k = limit+1 if never seen
  task automatic wait_valid_a(input int limit, output int k);
    bit got;
    got = 1'b0;
    k   = 0;
    while (!got && k <= limit) begin
      @(negedge clk);
      k++;
      if (bus_a.range_valid === 1'b1) got = 1'b1;
    end
  endtask

  // One full window on bus_a starting at the negedge right after an update strobe
  task automatic window(input int n, input bit late, input logic [1:0] exp_rng,
                        input int exp_cnt, input string name);
    int early;
    early = 0;
    for (int j = 0; j < WIN; j++) begin
      if (j > 0 && bus_a.range_valid !== 1'b0) early++;
      bus_a.pulse_in = ((j < 4 * n) && (j % 4 < 3)) || (late && j >= 97);
      @(negedge clk);
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL %s_early_strobe got %0d exp 0", name, early);
    end
    checks++;
    if (bus_a.range_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid got %b exp 1", name, bus_a.range_valid);
    end
    checks++;
    if (bus_a.rev_range !== exp_rng) begin
      errors++; $display("FAIL %s_range got %b exp %b", name, bus_a.rev_range, exp_rng);
    end
    checks++;
    if (bus_a.pulse_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL %s_count got %0d exp %0d", name, bus_a.pulse_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.pulse_in = 1'b0; bus_a.ign_on = 1'b0;
    bus_b.pulse_in = 1'b0; bus_b.ign_on = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_a.rev_range !== 2'b00) begin
      errors++; $display("FAIL reset_range got %b exp 00", bus_a.rev_range);
    end
    checks++;
    if (bus_a.range_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", bus_a.range_valid);
    end
    checks++;
    if (bus_a.pulse_count !== '0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", bus_a.pulse_count);
    end
    reset = 1'b0;
    // OFF with pulses present: nothing may be reported
    for (int j = 0; j < 20; j++) begin
      bus_a.pulse_in = (j % 4 < 3);
      @(negedge clk);
    end
    bus_a.pulse_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_a.range_valid !== 1'b0 || bus_a.pulse_count !== '0) begin
      errors++; $display("FAIL off_idle got valid %b count %0d exp 0 0",
                         bus_a.range_valid, bus_a.pulse_count);
    end
  endtask

  task automatic test_acq_timing();
    int k;
    bus_a.ign_on = 1'b1;
    wait_valid_a(300, k);
    // ACQ is entered at the first posedge; the strobe appears 100 cycles later
    checks++;
    if (k != 101) begin
      errors++; $display("FAIL acq_latency got %0d exp 101", k);
    end
    checks++;
    if (bus_a.rev_range !== 2'b00 || bus_a.pulse_count !== '0) begin
      errors++; $display("FAIL acq_result got %b/%0d exp 00/0", bus_a.rev_range, bus_a.pulse_count);
    end
    wait_valid_a(300, k);
    checks++;
    if (k != 100) begin
      errors++; $display("FAIL window_period got %0d exp 100", k);
    end
  endtask

  task automatic test_ranges();
    window(4,  1'b0, 2'b00, 4,  "w4");
    window(5,  1'b0, 2'b01, 5,  "w5");
    window(9,  1'b0, 2'b01, 9,  "w9");
    window(10, 1'b0, 2'b10, 10, "w10");
    window(19, 1'b0, 2'b10, 19, "w19");
    window(20, 1'b0, 2'b11, 20, "w20");
  endtask

  task automatic test_terminal_edge();
    window(4, 1'b1, 2'b01, 5, "term_edge");
    window(0, 1'b0, 2'b00, 0, "after_term");
  endtask

  task automatic test_hysteresis();
    window(10, 1'b0, 2'b10,  10, "hyst_base");
    window(9,  1'b0, EXP_H9, 9,  "hyst_9");
    window(7,  1'b0, 2'b01,  7,  "hyst_7");
  endtask

  task automatic test_ign_drop();
    int k;
    int stray;
    window(10, 1'b0, 2'b10, 10, "pre_drop");
    for (int j = 0; j < 50; j++) begin
      bus_a.pulse_in = (j < 20) && (j % 4 < 3);
      @(negedge clk);
    end
    bus_a.ign_on = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.rev_range !== 2'b00 || bus_a.range_valid !== 1'b0 || bus_a.pulse_count !== '0) begin
      errors++; $display("FAIL drop_off got %b/%b/%0d exp 00/0/0",
                         bus_a.rev_range, bus_a.range_valid, bus_a.pulse_count);
    end
    stray = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (bus_a.range_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL drop_stray_valid got %0d exp 0", stray);
    end
    bus_a.ign_on = 1'b1;
    wait_valid_a(300, k);
    checks++;
    if (k != 101) begin
      errors++; $display("FAIL reacq_latency got %0d exp 101", k);
    end
  endtask

  task automatic test_ign_terminal();
    window(10, 1'b0, 2'b10, 10, "pre_term_drop");
    for (int j = 0; j < WIN; j++) begin
      bus_a.pulse_in = (j < 40) && (j % 4 < 3);
      if (j == 99) bus_a.ign_on = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bus_a.range_valid !== 1'b0 || bus_a.rev_range !== 2'b00) begin
      errors++; $display("FAIL term_drop got valid %b range %b exp 0 00",
                         bus_a.range_valid, bus_a.rev_range);
    end
  endtask

  task automatic test_saturation();
    bit got;
    got = 1'b0;
    bus_b.ign_on = 1'b1;
    for (int j = 0; j < 1300 && !got; j++) begin
      bus_b.pulse_in = (j < 1200) && (j % 4 < 2);
      @(negedge clk);
      if (bus_b.range_valid === 1'b1) got = 1'b1;
    end
    bus_b.pulse_in = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL sat_timeout got no strobe exp strobe within 1300 cycles");
    end
    checks++;
    if (bus_b.pulse_count !== 8'd255) begin
      errors++; $display("FAIL sat_count got %0d exp 255", bus_b.pulse_count);
    end
    checks++;
    if (bus_b.rev_range !== 2'b11) begin
      errors++; $display("FAIL sat_range got %b exp 11", bus_b.rev_range);
    end
  endtask

  task automatic test_reset_mid_window();
    int k;
    bus_a.ign_on = 1'b1;
    wait_valid_a(300, k);
    window(10, 1'b0, 2'b10, 10, "pre_reset");
    for (int j = 0; j < 30; j++) begin
      bus_a.pulse_in = (j % 4 < 3);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus_a.rev_range !== 2'b00 || bus_a.pulse_count !== '0 || bus_a.range_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %b/%0d/%b exp 00/0/0",
                         bus_a.rev_range, bus_a.pulse_count, bus_a.range_valid);
    end
    @(negedge clk);
    bus_a.pulse_in = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_acq_timing();
    test_ranges();
    test_terminal_edge();
    test_hysteresis();
    test_ign_drop();
    test_ign_terminal();
    test_saturation();
    test_reset_mid_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
